// File: rtl/ysyx_24120009_exu_if.sv
// Handshake/data bundle between IDU, EXU and LSU/WBU.
// The slave modport is the EXU view; the master modport is the surrounding pipeline view.
interface ysyx_24120009_exu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_rs1_data;
    logic [DATA_WIDTH-1:0] in_rs2_data;
    logic [DATA_WIDTH-1:0] in_imm;
    logic [1:0]            in_src1_sel;
    logic [1:0]            in_src2_sel;
    logic [4:0]            in_alu_fun;
    logic [3:0]            in_br_type;
    logic [4:0]            in_rd;
    logic                  in_rd_wen;
    logic [CTRL_WIDTH-1:0] in_ctrl;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_result;
    logic [DATA_WIDTH-1:0] out_store_data;
    logic [4:0]            out_rd;
    logic                  out_rd_wen;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_redirect;
    logic [DATA_WIDTH-1:0] out_redirect_pc;
    logic                  out_alu_err;

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_src1_sel, in_src2_sel, in_alu_fun, in_br_type,
               in_rd, in_rd_wen, in_ctrl, out_ready,
        output in_ready, out_valid, out_pc, out_result, out_store_data,
               out_rd, out_rd_wen, out_ctrl, out_redirect, out_redirect_pc,
               out_alu_err
    );

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_src1_sel, in_src2_sel, in_alu_fun, in_br_type,
               in_rd, in_rd_wen, in_ctrl, out_ready,
        input  in_ready, out_valid, out_pc, out_result, out_store_data,
               out_rd, out_rd_wen, out_ctrl, out_redirect, out_redirect_pc,
               out_alu_err
    );
endinterface

// File: rtl/ysyx_24120009_exu.sv
// Execute stage: operand select, ALU, branch resolution, registered one-deep output.
// Define YSYX_24120009_EXU_SKID_EN to add a one-entry skid buffer with a registered in_ready.
module ysyx_24120009_exu #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    ysyx_24120009_exu_if.slave      bus
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] result;
        logic [DATA_WIDTH-1:0] store_data;
        logic [4:0]            rd;
        logic                  rd_wen;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic                  redirect;
        logic [DATA_WIDTH-1:0] redirect_pc;
        logic                  alu_err;
    } bundle_t;

    logic [DATA_WIDTH-1:0] w_alu_a;
    logic [DATA_WIDTH-1:0] w_alu_b;
    logic [4:0]            w_shamt;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic                  w_alu_err;
    logic                  w_eq;
    logic                  w_lt;
    logic                  w_ltu;
    logic                  w_taken;
    logic [DATA_WIDTH-1:0] w_br_target;
    logic [DATA_WIDTH-1:0] w_jalr_sum;
    logic [DATA_WIDTH-1:0] w_target;
    bundle_t               w_next;
    logic                  w_in_ready;
    logic                  w_out_free;
    logic                  w_accept;

    logic                  r_out_valid;
    bundle_t               r_out;

    always_comb begin
        w_alu_a = '0;
        case (bus.in_src1_sel)
            2'd0:    w_alu_a = bus.in_rs1_data;
            2'd1:    w_alu_a = bus.in_pc;
            default: w_alu_a = '0;
        endcase
    end

    always_comb begin
        w_alu_b = '0;
        case (bus.in_src2_sel)
            2'd0:    w_alu_b = bus.in_rs2_data;
            2'd1:    w_alu_b = bus.in_imm;
            2'd2:    w_alu_b = DATA_WIDTH'(4);
            default: w_alu_b = '0;
        endcase
    end

    assign w_shamt = w_alu_b[4:0];

    // Unknown codes produce zero and flag the error; the rest of the bundle still flows.
    always_comb begin
        w_alu_res = '0;
        w_alu_err = 1'b0;
        case (bus.in_alu_fun)
            5'd0:  w_alu_res = w_alu_a + w_alu_b;
            5'd1:  w_alu_res = w_alu_a - w_alu_b;
            5'd2:  w_alu_res[0] = $signed(w_alu_a) < $signed(w_alu_b);
            5'd3:  w_alu_res[0] = w_alu_a < w_alu_b;
            5'd4:  w_alu_res = w_alu_a ^ w_alu_b;
            5'd5:  w_alu_res = w_alu_a | w_alu_b;
            5'd6:  w_alu_res = w_alu_a & w_alu_b;
            5'd7:  w_alu_res = w_alu_a << w_shamt;
            5'd8:  w_alu_res = w_alu_a >> w_shamt;
            5'd9:  w_alu_res = $signed(w_alu_a) >>> w_shamt;
            5'd10: w_alu_res = w_alu_a;
            default: begin
                w_alu_res = '0;
                w_alu_err = 1'b1;
            end
        endcase
    end

    assign w_eq        = bus.in_rs1_data == bus.in_rs2_data;
    assign w_lt        = $signed(bus.in_rs1_data) < $signed(bus.in_rs2_data);
    assign w_ltu       = bus.in_rs1_data < bus.in_rs2_data;
    assign w_br_target = bus.in_pc + bus.in_imm;
    assign w_jalr_sum  = bus.in_rs1_data + bus.in_imm;

    always_comb begin
        w_taken  = 1'b0;
        w_target = w_br_target;
        case (bus.in_br_type)
            4'd1: w_taken = w_eq;
            4'd2: w_taken = !w_eq;
            4'd3: w_taken = w_lt;
            4'd4: w_taken = !w_lt;
            4'd5: w_taken = w_ltu;
            4'd6: w_taken = !w_ltu;
            4'd7: w_taken = 1'b1;
            4'd8: begin
                w_taken  = 1'b1;
                w_target = {w_jalr_sum[DATA_WIDTH-1:1], 1'b0};
            end
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next             = '0;
        w_next.pc          = bus.in_pc;
        w_next.result      = w_alu_res;
        w_next.store_data  = bus.in_rs2_data;
        w_next.rd          = bus.in_rd;
        w_next.rd_wen      = bus.in_rd_wen;
        w_next.ctrl        = bus.in_ctrl;
        w_next.redirect    = w_taken;
        w_next.redirect_pc = w_taken ? w_target : '0;
        w_next.alu_err     = w_alu_err;
    end

    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

`ifdef YSYX_24120009_EXU_SKID_EN
    logic    r_skid_full;
    bundle_t r_skid;

    assign w_in_ready = !r_skid_full;

    // The skid always drains ahead of new input, so in_ready stays low until it empties.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_skid_full <= 1'b0;
            r_skid      <= '0;
        end else if (w_out_free) begin
            if (r_skid_full) begin
                r_out       <= r_skid;
                r_out_valid <= 1'b1;
                r_skid_full <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_next;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid      <= w_next;
            r_skid_full <= 1'b1;
        end
    end
`else
    assign w_in_ready = w_out_free;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_accept) begin
            r_out       <= w_next;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    assign bus.in_ready        = w_in_ready;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_pc          = r_out.pc;
    assign bus.out_result      = r_out.result;
    assign bus.out_store_data  = r_out.store_data;
    assign bus.out_rd          = r_out.rd;
    assign bus.out_rd_wen      = r_out.rd_wen;
    assign bus.out_ctrl        = r_out.ctrl;
    assign bus.out_redirect    = r_out.redirect;
    assign bus.out_redirect_pc = r_out.redirect_pc;
    assign bus.out_alu_err     = r_out.alu_err;

endmodule

// File: tb/tb_ysyx_24120009_exu.sv
// Bench for ysyx_24120009_exu: vector table through a scoreboard, plus backpressure and reset sequences.
module tb_ysyx_24120009_exu;
    localparam int DW = 32;
    localparam int CW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_24120009_exu_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

    ysyx_24120009_exu #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [7:0]  ctrl;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        alu_err;
    } exp_t;

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [1:0]  s1, s2;
        logic [4:0]  fun;
        logic [3:0]  br;
        logic [31:0] result;
        logic        redir;
        logic [31:0] rpc;
        logic        err;
    } vec_t;

    typedef struct {
        exp_t e;
        int   id;
    } sb_t;

    sb_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[25];
    logic prev_stall_acc = 1'b0;

    function automatic vec_t mk(input logic [31:0] pc, rs1, rs2, imm,
                                input logic [1:0] s1, s2, input logic [4:0] fun,
                                input logic [3:0] br, input logic [31:0] result,
                                input logic redir, input logic [31:0] rpc, input logic err);
        vec_t v;
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.s1 = s1; v.s2 = s2; v.fun = fun; v.br = br;
        v.result = result; v.redir = redir; v.rpc = rpc; v.err = err;
        return v;
    endfunction

    function automatic exp_t cur_out();
        exp_t a;
        a.pc = bus.out_pc; a.result = bus.out_result; a.store_data = bus.out_store_data;
        a.rd = bus.out_rd; a.rd_wen = bus.out_rd_wen; a.ctrl = bus.out_ctrl;
        a.redirect = bus.out_redirect; a.redirect_pc = bus.out_redirect_pc;
        a.alu_err = bus.out_alu_err;
        return a;
    endfunction

    task automatic send(input vec_t v, input int id);
        logic [7:0] idb;
        logic       acc;
        sb_t        s;
        idb = id[7:0];
        bus.in_pc = v.pc; bus.in_rs1_data = v.rs1; bus.in_rs2_data = v.rs2; bus.in_imm = v.imm;
        bus.in_src1_sel = v.s1; bus.in_src2_sel = v.s2; bus.in_alu_fun = v.fun; bus.in_br_type = v.br;
        bus.in_rd = idb[4:0]; bus.in_rd_wen = idb[0]; bus.in_ctrl = idb ^ 8'hA5;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 40 && !acc; c++) begin
            @(negedge clock);
            if (bus.in_ready === 1'b1) begin
                s.id = id;
                s.e.pc = v.pc; s.e.result = v.result; s.e.store_data = v.rs2;
                s.e.rd = idb[4:0]; s.e.rd_wen = idb[0]; s.e.ctrl = idb ^ 8'hA5;
                s.e.redirect = v.redir; s.e.redirect_pc = v.rpc; s.e.alu_err = v.err;
                exp_q.push_back(s);
                acc = 1'b1;
            end
        end
        if (!acc) begin
            tests++; fails++;
            $display("FAIL accept_timeout id=%0d in_ready=%b required=1", id, bus.in_ready);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(posedge clock);
        #1;
    endtask

    // Output side of the scoreboard and in_ready protocol checks.
    always @(negedge clock) begin
        exp_t act;
        sb_t  s;
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                act = cur_out();
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output actual=%h required=no output", act);
                end else begin
                    s = exp_q.pop_front();
                    if (act !== s.e) begin
                        fails++;
                        $display("FAIL vec%0d actual=%h required=%h", s.id, act, s.e);
                    end
                end
            end
`ifdef YSYX_24120009_EXU_SKID_EN
            if (prev_stall_acc) begin
                tests++;
                if (bus.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL skid_ready_drop in_ready=%b required=0", bus.in_ready);
                end
            end
            prev_stall_acc = bus.out_valid && !bus.out_ready && bus.in_valid && bus.in_ready;
`else
            if (bus.out_valid && !bus.out_ready) begin
                tests++;
                if (bus.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_ready in_ready=%b required=0", bus.in_ready);
                end
            end
`endif
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_rs1_data = '0; bus.in_rs2_data = '0;
        bus.in_imm = '0; bus.in_src1_sel = '0; bus.in_src2_sel = '0; bus.in_alu_fun = '0;
        bus.in_br_type = '0; bus.in_rd = '0; bus.in_rd_wen = 1'b0; bus.in_ctrl = '0;
        bus.out_ready = 1'b1;

        //            pc            rs1           rs2           imm          s1 s2 fun br  result        rd rpc          err
        vecs[0]  = mk(32'h0,        32'hFFFFFFF0, 32'h0,        32'h20,       1, 1, 0, 0, 32'h00000010, 0, 32'h0,        0);
        vecs[0].s1 = 2'd0;
        vecs[1]  = mk(32'h0,        32'hFFFFFFF0, 32'h0,        32'h20,       0, 1, 3, 0, 32'h0,        0, 32'h0,        0);
        vecs[2]  = mk(32'h0,        32'hFFFFFFF0, 32'h0,        32'h20,       0, 1, 2, 0, 32'h1,        0, 32'h0,        0);
        vecs[3]  = mk(32'h4,        32'h5,        32'h7,        32'h0,        0, 0, 1, 0, 32'hFFFFFFFE, 0, 32'h0,        0);
        vecs[4]  = mk(32'h8,        32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        0, 0, 4, 0, 32'h0FF00FF0, 0, 32'h0,        0);
        vecs[5]  = mk(32'hC,        32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        0, 0, 5, 0, 32'hFFF0FFF0, 0, 32'h0,        0);
        vecs[6]  = mk(32'h10,       32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        0, 0, 6, 0, 32'hF000F000, 0, 32'h0,        0);
        vecs[7]  = mk(32'h14,       32'h1,        32'h0,        32'h24,       0, 1, 7, 0, 32'h00000010, 0, 32'h0,        0);
        vecs[8]  = mk(32'h18,       32'h80000000, 32'h0,        32'h4,        0, 1, 8, 0, 32'h08000000, 0, 32'h0,        0);
        vecs[9]  = mk(32'h1C,       32'h80000000, 32'h0,        32'h4,        0, 1, 9, 0, 32'hF8000000, 0, 32'h0,        0);
        vecs[10] = mk(32'h1234,     32'h9,        32'h0,        32'h0,        1, 0, 10, 0, 32'h00001234, 0, 32'h0,       0);
        vecs[11] = mk(32'h20,       32'h9,        32'h9,        32'h9,        2, 2, 0, 0, 32'h4,        0, 32'h0,        0);
        vecs[12] = mk(32'h24,       32'h5,        32'h5,        32'h5,        3, 3, 0, 0, 32'h0,        0, 32'h0,        0);
        vecs[13] = mk(32'h80000000, 32'h5,        32'h5,        32'h10,       0, 0, 0, 1, 32'hA,        1, 32'h80000010, 0);
        vecs[14] = mk(32'h80000000, 32'h5,        32'h5,        32'h10,       0, 0, 0, 2, 32'hA,        0, 32'h0,        0);
        vecs[15] = mk(32'h100,      32'hFFFFFFFF, 32'h1,        32'hFFFFFFF0, 0, 0, 10, 3, 32'hFFFFFFFF, 1, 32'hF0,       0);
        vecs[16] = mk(32'h100,      32'hFFFFFFFF, 32'h1,        32'hFFFFFFF0, 0, 0, 10, 5, 32'hFFFFFFFF, 0, 32'h0,        0);
        vecs[17] = mk(32'h100,      32'hFFFFFFFF, 32'h1,        32'hFFFFFFF0, 0, 0, 10, 4, 32'hFFFFFFFF, 0, 32'h0,        0);
        vecs[18] = mk(32'h100,      32'hFFFFFFFF, 32'h1,        32'hFFFFFFF0, 0, 0, 10, 6, 32'hFFFFFFFF, 1, 32'hF0,       0);
        vecs[19] = mk(32'h80000000, 32'h0,        32'h0,        32'h100,      1, 2, 0, 7, 32'h80000004, 1, 32'h80000100, 0);
        vecs[20] = mk(32'h80000000, 32'h80001003, 32'h0,        32'h0,        1, 2, 0, 8, 32'h80000004, 1, 32'h80001002, 0);
        vecs[21] = mk(32'h28,       32'h5,        32'h0,        32'h3,        0, 1, 15, 0, 32'h0,       0, 32'h0,        1);
        vecs[22] = mk(32'h2C,       32'h5,        32'h0,        32'h3,        0, 1, 0, 0, 32'h8,        0, 32'h0,        0);
        vecs[23] = mk(32'h40,       32'h5,        32'h5,        32'h4,        0, 0, 0, 12, 32'hA,       0, 32'h0,        0);
        vecs[24] = mk(32'h0,        32'h3,        32'h3,        32'h8,        0, 0, 0, 4, 32'h6,        1, 32'h8,        0);

        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || cur_out() !== '0) begin
            fails++;
            $display("FAIL reset_state out_valid=%b bundle=%h required=0", bus.out_valid, cur_out());
        end
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset in_ready=%b required=1", bus.in_ready);
        end

        @(posedge clock);
        #1;
        for (int i = 0; i < 25; i++) send(vecs[i], i);
        drain();

        // Four tagged instructions against a 3-cycle output stall.
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send(mk(32'h3000 + 32'(k * 4), 32'hA0 + 32'(k), 32'h0, 32'h0, 0, 0, 10, 0,
                            32'hA0 + 32'(k), 0, 32'h0, 0), 100 + k);
            end
            begin
                repeat (3) @(posedge clock);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset while a result is held stalled at the output.
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        send(vecs[19], 200);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || cur_out() !== '0) begin
            fails++;
            $display("FAIL reset_midstream out_valid=%b bundle=%h required=0", bus.out_valid, cur_out());
        end
        exp_q.delete();
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL ready_after_midreset in_ready=%b out_valid=%b required=1/0",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clock);
        #1;
        send(vecs[0], 201);
        drain();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover pending=%0d required=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
